// File: rtl/gpr_wb_arbiter_pkg.sv
// rtl/gpr_wb_arbiter_pkg.sv - shared widths and the queued write-back entry type
package gpr_wb_arbiter_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rw;
    logic [DATA_W-1:0] wd;
  } wb_entry_t;
endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// rtl/gpr_wb_arbiter_if.sv - result sources, scoreboard and GPR write port bundle
interface gpr_wb_arbiter_if;
  import gpr_wb_arbiter_pkg::*;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rw;
  logic [DATA_W-1:0] alu_wd;
  logic              alu_ovf;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_AW-1:0] lsu_rw;
  logic [DATA_W-1:0] lsu_wd;
  logic              sb_alloc;
  logic [REG_AW-1:0] sb_alloc_rw;
  logic [31:0]       sb_busy;
  logic              alu_stall;
  logic              gpr_we;
  logic [REG_AW-1:0] gpr_rw;
  logic [DATA_W-1:0] gpr_wd;
  logic              gpr_ovf;
  logic              overflag;

  modport master (
    output alu_valid, alu_rw, alu_wd, alu_ovf, lsu_valid, lsu_rw, lsu_wd, sb_alloc, sb_alloc_rw,
    input  lsu_ready, sb_busy, alu_stall, gpr_we, gpr_rw, gpr_wd, gpr_ovf, overflag
  );

  modport slave (
    input  alu_valid, alu_rw, alu_wd, alu_ovf, lsu_valid, lsu_rw, lsu_wd, sb_alloc, sb_alloc_rw,
    output lsu_ready, sb_busy, alu_stall, gpr_we, gpr_rw, gpr_wd, gpr_ovf, overflag
  );
endinterface

// File: rtl/gpr_wb_arbiter_fifo.sv
// rtl/gpr_wb_arbiter_fifo.sv - synchronous queue of long-latency write-back entries
module gpr_wb_arbiter_fifo
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  wb_entry_t     din_i,
  input  logic          pop_i,
  output wb_entry_t     head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  wb_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  // Caller guarantees push only when not full and pop only when not empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_i && !pop_i)      count_q <= count_q + CW'(1);
      else if (pop_i && !push_i) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - merges ALU and queued long-latency results onto the GPR write port
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input logic            clk,
  input logic            rst,
  gpr_wb_arbiter_if.slave wb
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  wb_entry_t         head, push_entry;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_push, fifo_pop, alu_win, stall;
  logic [SW-1:0]     starve_q, starve_d;
  logic [31:0]       sb_q, sb_d;
  logic              gpr_we_q, gpr_ovf_q, overflag_q;
  logic [REG_AW-1:0] gpr_rw_q;
  logic [DATA_W-1:0] gpr_wd_q;

  assign push_entry = '{rw: wb.lsu_rw, wd: wb.lsu_wd};

  gpr_wb_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (push_entry),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Ready comes from the registered count, so a pop never frees a slot in the same cycle.
  always_comb begin
    stall     = (starve_q == STARVE_C) && !fifo_empty;
    alu_win   = wb.alu_valid && !stall;
    fifo_pop  = !fifo_empty && !alu_win;
    fifo_push = wb.lsu_valid && (fifo_count != DEPTH_C) && (wb.lsu_rw != '0);
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop)               starve_d = '0;
    else if (alu_win && starve_q != STARVE_C) starve_d = starve_q + SW'(1);
  end

  // Clear before set so a same-cycle reservation of the committing register survives.
  always_comb begin
    sb_d = sb_q;
    if (fifo_pop) sb_d[head.rw] = 1'b0;
    if (wb.sb_alloc && wb.sb_alloc_rw != '0) sb_d[wb.sb_alloc_rw] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      sb_q       <= '0;
      gpr_we_q   <= 1'b0;
      gpr_ovf_q  <= 1'b0;
      gpr_rw_q   <= '0;
      gpr_wd_q   <= '0;
      overflag_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      sb_q     <= sb_d;
      if (alu_win) begin
        gpr_we_q  <= (wb.alu_rw != '0) && !wb.alu_ovf;
        gpr_ovf_q <= wb.alu_ovf;
        gpr_rw_q  <= wb.alu_rw;
        gpr_wd_q  <= wb.alu_wd;
        if (wb.alu_ovf) overflag_q <= 1'b1;
      end else if (fifo_pop) begin
        gpr_we_q  <= (head.rw != '0);
        gpr_ovf_q <= 1'b0;
        gpr_rw_q  <= head.rw;
        gpr_wd_q  <= head.wd;
      end else begin
        gpr_we_q  <= 1'b0;
        gpr_ovf_q <= 1'b0;
      end
    end
  end

  assign wb.lsu_ready = (fifo_count != DEPTH_C);
  assign wb.alu_stall = stall;
  assign wb.sb_busy   = sb_q;
  assign wb.gpr_we    = gpr_we_q;
  assign wb.gpr_rw    = gpr_rw_q;
  assign wb.gpr_wd    = gpr_wd_q;
  assign wb.gpr_ovf   = gpr_ovf_q;
  assign wb.overflag  = overflag_q;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb/tb_gpr_wb_arbiter.sv - self-checking bench for the GPR write-back arbiter
module tb_gpr_wb_arbiter;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpr_wb_arbiter_if bus ();

  gpr_wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rw;
    logic [31:0] wd;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  logic [31:0] m_busy;
  logic        m_we, m_ovf, m_of;
  logic [4:0]  m_rw;
  logic [31:0] m_wd;
  logic        m_accepted;

  typedef struct {
    logic        av;
    logic [4:0]  rw;
    logic [31:0] wd;
    logic        ovf;
    logic        e_we;
    logic [4:0]  e_rw;
    logic [31:0] e_wd;
    logic        e_ovf;
    logic        e_of;
  } vec_t;

  vec_t tbl[6];

  function automatic bit m_stall();
    return (m_starve == STARVE_MAX) && (mq.size() > 0);
  endfunction

  function automatic bit m_ready();
    return mq.size() < FIFO_DEPTH;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_busy = '0;
    m_we = 0; m_ovf = 0; m_of = 0;
    m_rw = '0; m_wd = '0;
    m_accepted = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gpr_we"},    32'(bus.gpr_we),    32'(m_we));
    chk({tag, ".gpr_ovf"},   32'(bus.gpr_ovf),   32'(m_ovf));
    chk({tag, ".gpr_rw"},    32'(bus.gpr_rw),    32'(m_rw));
    chk({tag, ".gpr_wd"},    bus.gpr_wd,         m_wd);
    chk({tag, ".overflag"},  32'(bus.overflag),  32'(m_of));
    chk({tag, ".lsu_ready"}, 32'(bus.lsu_ready), 32'(m_ready()));
    chk({tag, ".alu_stall"}, 32'(bus.alu_stall), 32'(m_stall()));
    chk({tag, ".sb_busy"},   bus.sb_busy,        m_busy);
  endtask

  // Drives one cycle of inputs and advances the model to the state expected after the next edge.
  task automatic apply(input logic av, input logic [4:0] arw, input logic [31:0] awd, input logic aovf,
                       input logic lv, input logic [4:0] lrw, input logic [31:0] lwd,
                       input logic al, input logic [4:0] alrw);
    bit stall_now, ready_now, alu_wins;
    ent_t e;
    bus.alu_valid = av; bus.alu_rw = arw; bus.alu_wd = awd; bus.alu_ovf = aovf;
    bus.lsu_valid = lv; bus.lsu_rw = lrw; bus.lsu_wd = lwd;
    bus.sb_alloc = al; bus.sb_alloc_rw = alrw;
    stall_now = m_stall();
    ready_now = m_ready();
    alu_wins  = av && !stall_now;
    m_accepted = lv && ready_now;
    if (alu_wins) begin
      m_we = (arw != 0) && !aovf; m_ovf = aovf; m_rw = arw; m_wd = awd;
      if (aovf) m_of = 1;
      m_starve = (mq.size() == 0) ? 0 : ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = (e.rw != 0); m_ovf = 0; m_rw = e.rw; m_wd = e.wd;
      m_busy[e.rw] = 1'b0;
      m_starve = 0;
    end else begin
      m_we = 0; m_ovf = 0;
      m_starve = 0;
    end
    if (m_accepted && lrw != 0) mq.push_back('{rw: lrw, wd: lwd});
    if (al && alrw != 0) m_busy[alrw] = 1'b1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all("reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int wins, waits;
    tbl[0] = '{1, 5'd5, 32'h1234, 0, 1, 5'd5, 32'h1234, 0, 0};
    tbl[1] = '{0, 5'd0, 32'h0,    0, 0, 5'd5, 32'h1234, 0, 0};
    tbl[2] = '{1, 5'd0, 32'h55,   0, 0, 5'd0, 32'h55,   0, 0};
    tbl[3] = '{1, 5'd7, 32'h77,   1, 0, 5'd7, 32'h77,   1, 1};
    tbl[4] = '{0, 5'd0, 32'h0,    0, 0, 5'd7, 32'h77,   0, 1};
    tbl[5] = '{1, 5'd3, 32'hCAFE, 0, 1, 5'd3, 32'hCAFE, 0, 1};

    model_reset();
    idle();
    do_reset();
    chk("reset_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    chk("reset_gpr_we", 32'(bus.gpr_we), 32'd0);

    foreach (tbl[i]) begin
      apply(tbl[i].av, tbl[i].rw, tbl[i].wd, tbl[i].ovf, 0, 0, 0, 0, 0);
      tick($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.we", i),  32'(bus.gpr_we),   32'(tbl[i].e_we));
      chk($sformatf("tbl%0d.rw", i),  32'(bus.gpr_rw),   32'(tbl[i].e_rw));
      chk($sformatf("tbl%0d.wd", i),  bus.gpr_wd,        tbl[i].e_wd);
      chk($sformatf("tbl%0d.ovf", i), 32'(bus.gpr_ovf),  32'(tbl[i].e_ovf));
      chk($sformatf("tbl%0d.of", i),  32'(bus.overflag), 32'(tbl[i].e_of));
    end
    do_reset();
    chk("overflag_cleared", 32'(bus.overflag), 32'd0);

    // Reservation, push, commit two cycles after push, bit clears.
    apply(0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    tick("alloc");
    chk("sb9_set", 32'(bus.sb_busy[9]), 32'd1);
    apply(0, 0, 0, 0, 1, 5'd9, 32'hBEEF, 0, 0);
    tick("push9");
    chk("push9_no_we", 32'(bus.gpr_we), 32'd0);
    idle();
    tick("pop9");
    chk("wr9_we", 32'(bus.gpr_we), 32'd1);
    chk("wr9_rw", 32'(bus.gpr_rw), 32'd9);
    chk("wr9_wd", bus.gpr_wd, 32'hBEEF);
    chk("sb9_clr", 32'(bus.sb_busy[9]), 32'd0);

    // Fill the FIFO while the ALU keeps winning; fifth entry waits for the starvation pop.
    for (int k = 1; k <= 4; k++) begin
      apply(!m_stall(), 5'(20 + k), 32'(k), 0, 1, 5'(k), 32'h100 + 32'(k), 0, 0);
      tick($sformatf("fill%0d", k));
    end
    chk("full_not_ready", 32'(bus.lsu_ready), 32'd0);
    waits = 0;
    while (!bus.lsu_ready && waits < 8) begin
      apply(0, 0, 0, 0, 1, 5'd5, 32'h105, 0, 0);
      tick("hold5");
      waits++;
    end
    chk("hold5_waits", 32'(waits), 32'd1);
    apply(0, 0, 0, 0, 1, 5'd5, 32'h105, 0, 0);
    chk("push5_accept", 32'(m_accepted), 32'd1);
    tick("push5");
    for (int k = 0; k < 6; k++) begin
      idle();
      tick("drain");
    end

    // Single queued entry starved by back-to-back ALU results.
    apply(0, 0, 0, 0, 1, 5'd12, 32'hA5A5, 0, 0);
    tick("starve_push");
    wins = 0;
    while (!bus.alu_stall && wins < 10) begin
      apply(1, 5'd13, 32'(wins), 0, 0, 0, 0, 0, 0);
      tick("starve_alu");
      wins++;
    end
    chk("starve_wins", 32'(wins), 32'(STARVE_MAX));
    idle();
    tick("starve_commit");
    chk("starve_commit_rw", 32'(bus.gpr_rw), 32'd12);
    chk("starve_commit_we", 32'(bus.gpr_we), 32'd1);

    // r0 destinations from both sources never write and never queue.
    apply(1, 5'd0, 32'h11, 0, 1, 5'd0, 32'h22, 0, 0);
    tick("r0_a");
    idle();
    tick("r0_b");
    chk("r0_no_we", 32'(bus.gpr_we), 32'd0);
    idle();
    tick("r0_c");

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic av;
      av = ($urandom_range(0, 2) != 0) && !m_stall();
      apply(av, 5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 7) == 0),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
      tick("rand");
    end

    // Asynchronous reset with entries queued and registers reserved.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply(1, 5'(1 + k), 32'(k), 0, 1, 5'(10 + k), 32'h200 + 32'(k), 1, 5'(10 + k));
      tick("preq");
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_sb_busy", bus.sb_busy, 32'd0);
    chk("arst_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    chk("arst_gpr_we", 32'(bus.gpr_we), 32'd0);
    chk("arst_alu_stall", 32'(bus.alu_stall), 32'd0);
    idle();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle();
      tick("post_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
